// File: rtl/calc_sequencer_if.sv
// Button, ALU handshake and display-side signals of the calculator sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface calc_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  btn_c;
  logic                  btn_u;
  logic                  btn_d;
  logic                  btn_l;
  logic                  btn_r;
  logic                  alu_done;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_error;
  logic [3:0]            ones;
  logic [3:0]            tens;
  logic [3:0]            hundreds;
  logic                  sign;
  logic [1:0]            cursor;
  logic [2:0]            phase;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [1:0]            op_sel;
  logic                  alu_start;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;
  logic                  err;

  modport master (
    input  btn_c, btn_u, btn_d, btn_l, btn_r, alu_done, alu_result, alu_error,
    output ones, tens, hundreds, sign, cursor, phase, op_a, op_b, op_sel,
           alu_start, result, result_valid, err
  );

  modport slave (
    output btn_c, btn_u, btn_d, btn_l, btn_r, alu_done, alu_result, alu_error,
    input  ones, tens, hundreds, sign, cursor, phase, op_a, op_b, op_sel,
           alu_start, result, result_valid, err
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator sequencer: edits a signed three-digit BCD operand, captures A, B
// and the operation, launches the ALU and holds its result for display.
module calc_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  calc_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    EDIT_A = 3'd0, EDIT_B = 3'd1, SEL_OP = 3'd2, RUN = 3'd3, SHOW = 3'd4
  } phase_t;

  typedef enum logic [2:0] {
    BTN_NONE = 3'd0, BTN_C = 3'd1, BTN_L = 3'd2, BTN_R = 3'd3, BTN_U = 3'd4, BTN_D = 3'd5
  } btn_t;

  phase_t                phase_r;
  logic [3:0]            ones_r;
  logic [3:0]            tens_r;
  logic [3:0]            hundreds_r;
  logic                  sign_r;
  logic [1:0]            cursor_r;
  logic [DATA_WIDTH-1:0] op_a_r;
  logic [DATA_WIDTH-1:0] op_b_r;
  logic [1:0]            op_sel_r;
  logic                  alu_start_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  result_valid_r;
  logic                  err_r;
  logic [CNT_W-1:0]      tmo_cnt_r;

  btn_t                  btn_s;
  logic [DATA_WIDTH-1:0] mag_s;
  logic [DATA_WIDTH-1:0] value_s;

  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic up);
    logic [3:0] n;
    if (up) begin
      if (d == 4'd9) n = d;
      else           n = d + 4'd1;
    end else begin
      if (d == 4'd0) n = d;
      else           n = d - 4'd1;
    end
    return n;
  endfunction

  // Pick the single acting button and form the signed value of the edited digits.
  always_comb begin
    btn_s = BTN_NONE;
    if (bus.btn_c)      btn_s = BTN_C;
    else if (bus.btn_l) btn_s = BTN_L;
    else if (bus.btn_r) btn_s = BTN_R;
    else if (bus.btn_u) btn_s = BTN_U;
    else if (bus.btn_d) btn_s = BTN_D;
    else                btn_s = BTN_NONE;

    mag_s = DATA_WIDTH'(hundreds_r) * DATA_WIDTH'(7'd100)
          + DATA_WIDTH'(tens_r) * DATA_WIDTH'(4'd10)
          + DATA_WIDTH'(ones_r);
    if (sign_r && (mag_s != {DATA_WIDTH{1'b0}})) value_s = -mag_s;
    else                                         value_s = mag_s;
  end

  // Sequencer state machine with all outputs held in registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r        <= EDIT_A;
      ones_r         <= 4'd0;
      tens_r         <= 4'd0;
      hundreds_r     <= 4'd0;
      sign_r         <= 1'b0;
      cursor_r       <= 2'd0;
      op_a_r         <= {DATA_WIDTH{1'b0}};
      op_b_r         <= {DATA_WIDTH{1'b0}};
      op_sel_r       <= 2'd0;
      alu_start_r    <= 1'b0;
      result_r       <= {DATA_WIDTH{1'b0}};
      result_valid_r <= 1'b0;
      err_r          <= 1'b0;
      tmo_cnt_r      <= {CNT_W{1'b0}};
    end else begin
      alu_start_r <= 1'b0;
      case (phase_r)
        EDIT_A, EDIT_B: begin
          case (btn_s)
            BTN_C: begin
              if (phase_r == EDIT_A) begin
                op_a_r  <= value_s;
                phase_r <= EDIT_B;
              end else begin
                op_b_r  <= value_s;
                phase_r <= SEL_OP;
              end
              ones_r     <= 4'd0;
              tens_r     <= 4'd0;
              hundreds_r <= 4'd0;
              sign_r     <= 1'b0;
              cursor_r   <= 2'd0;
            end
            BTN_L: cursor_r <= cursor_r + 2'd1;
            BTN_R: cursor_r <= cursor_r - 2'd1;
            BTN_U, BTN_D: begin
              case (cursor_r)
                2'd0:    ones_r     <= step_digit(ones_r, btn_s == BTN_U);
                2'd1:    tens_r     <= step_digit(tens_r, btn_s == BTN_U);
                2'd2:    hundreds_r <= step_digit(hundreds_r, btn_s == BTN_U);
                default: sign_r     <= ~sign_r;
              endcase
            end
            default: ;
          endcase
        end
        SEL_OP: begin
          case (btn_s)
            BTN_C: begin
              phase_r     <= RUN;
              alu_start_r <= 1'b1;
              tmo_cnt_r   <= {CNT_W{1'b0}};
            end
            BTN_U:   op_sel_r <= op_sel_r + 2'd1;
            BTN_D:   op_sel_r <= op_sel_r - 2'd1;
            default: ;
          endcase
        end
        RUN: begin
          // A done arriving together with the launch pulse belongs to nothing.
          if (bus.alu_done && !alu_start_r) begin
            result_r       <= bus.alu_result;
            err_r          <= bus.alu_error;
            result_valid_r <= 1'b1;
            phase_r        <= SHOW;
          end else if (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            result_r       <= {DATA_WIDTH{1'b0}};
            err_r          <= 1'b1;
            result_valid_r <= 1'b1;
            phase_r        <= SHOW;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
          end
        end
        SHOW: begin
          if (btn_s == BTN_C) begin
            phase_r        <= EDIT_A;
            ones_r         <= 4'd0;
            tens_r         <= 4'd0;
            hundreds_r     <= 4'd0;
            sign_r         <= 1'b0;
            cursor_r       <= 2'd0;
            op_a_r         <= {DATA_WIDTH{1'b0}};
            op_b_r         <= {DATA_WIDTH{1'b0}};
            op_sel_r       <= 2'd0;
            result_r       <= {DATA_WIDTH{1'b0}};
            result_valid_r <= 1'b0;
            err_r          <= 1'b0;
          end
        end
        default: phase_r <= EDIT_A;
      endcase
    end
  end

  assign bus.ones         = ones_r;
  assign bus.tens         = tens_r;
  assign bus.hundreds     = hundreds_r;
  assign bus.sign         = sign_r;
  assign bus.cursor       = cursor_r;
  assign bus.phase        = phase_r;
  assign bus.op_a         = op_a_r;
  assign bus.op_b         = op_b_r;
  assign bus.op_sel       = op_sel_r;
  assign bus.alu_start    = alu_start_r;
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.err          = err_r;
endmodule
